// File: rtl/alu_exec_unit.sv
// Two-stage execute ALU: S1 registers operands/control, S2 registers result and flags.
// Valid/ready handshakes on both sides, plus a counter of operations delivered downstream.
module alu_exec_unit #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           funcCode,
    input  logic [1:0]           branchType,
    input  logic                 is_branch,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 bcond,
    output logic                 overflow,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired_count
);

    logic                    vld_p0;
    logic [3:0]              func_p0;
    logic [1:0]              btype_p0;
    logic                    br_p0;
    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;

    logic                    accept;
    logic                    s2_load;
    logic signed [WIDTH-1:0] res_c;
    logic                    bcond_c;
    logic                    ovf_c;
    logic                    ill_c;

    // Overflow is detected by carrying one extra sign bit through the operation.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y);
        logic signed [WIDTH:0] s;
        s = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        return s[WIDTH] != s[WIDTH-1];
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y);
        logic signed [WIDTH:0] d;
        d = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        return d[WIDTH] != d[WIDTH-1];
    endfunction

    assign s2_load  = vld_p0 && (!out_valid || out_ready);
    assign in_ready = !vld_p0 || s2_load;
    assign accept   = in_valid && in_ready;

    // ---- S1: operand / control register ----
    always_ff @(posedge clk) begin
        if (reset)
            vld_p0 <= 1'b0;
        else if (accept)
            vld_p0 <= 1'b1;
        else if (s2_load)
            vld_p0 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            func_p0  <= funcCode;
            btype_p0 <= branchType;
            br_p0    <= is_branch;
            a_p0     <= A;
            b_p0     <= B;
        end
    end

    always_comb begin
        res_c   = '0;
        bcond_c = 1'b0;
        ovf_c   = 1'b0;
        ill_c   = 1'b0;
        if (br_p0) begin
            case (btype_p0)
                2'b00: bcond_c = (a_p0 != b_p0);
                2'b01: bcond_c = (a_p0 == b_p0);
                2'b10: bcond_c = (a_p0 > $signed({WIDTH{1'b0}}));
                2'b11: bcond_c = (a_p0 < $signed({WIDTH{1'b0}}));
            endcase
        end else begin
            case (func_p0)
                4'b0000: begin res_c = a_p0 + b_p0; ovf_c = add_ovf(a_p0, b_p0); end
                4'b0001: begin res_c = a_p0 - b_p0; ovf_c = sub_ovf(a_p0, b_p0); end
                4'b0010: res_c = a_p0 & b_p0;
                4'b0011: res_c = a_p0 | b_p0;
                4'b0100: res_c = ~a_p0;
                4'b0101: res_c = -a_p0;
                4'b0110: res_c = a_p0 <<< 1;
                4'b0111: res_c = a_p0 >>> 1;
                4'b1000: res_c = b_p0;
                default: ill_c = 1'b1;
            endcase
        end
    end

    // ---- S2: output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            bcond     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            result    <= res_c;
            bcond     <= bcond_c;
            overflow  <= ovf_c;
            illegal   <= ill_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            retired_count <= '0;
        else if (out_valid && out_ready)
            retired_count <= retired_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit; a 4-bit-counter instance shares the stimulus
// so the counter wrap is reached in a handful of operations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  funcCode;
    logic [1:0]  branchType;
    logic        is_branch;
    logic [15:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        bcond, overflow, illegal;
    logic [15:0] retired_count;

    logic        in_ready2, out_valid2, bcond2, overflow2, illegal2;
    logic [15:0] result2;
    logic [3:0]  retired_count2;

    typedef struct packed {
        logic [15:0] r;
        logic        bc;
        logic        ov;
        logic        il;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;
    int   nacc  = 0;
    int   base;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funcCode(funcCode), .branchType(branchType), .is_branch(is_branch),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .bcond(bcond), .overflow(overflow), .illegal(illegal),
        .retired_count(retired_count)
    );

    alu_exec_unit #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .funcCode(funcCode), .branchType(branchType), .is_branch(is_branch),
        .A(A), .B(B), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .bcond(bcond2), .overflow(overflow2), .illegal(illegal2),
        .retired_count(retired_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [1:0] bt, input logic br,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e = '0;
        if (br) begin
            case (bt)
                2'b00: e.bc = (a != b);
                2'b01: e.bc = (a == b);
                2'b10: e.bc = !a[15] && (a != 16'h0000);
                2'b11: e.bc = a[15];
            endcase
        end else begin
            case (f)
                4'd0: begin e.r = a + b; e.ov = (a[15] == b[15]) && (e.r[15] != a[15]); end
                4'd1: begin e.r = a - b; e.ov = (a[15] != b[15]) && (e.r[15] != a[15]); end
                4'd2: e.r = a & b;
                4'd3: e.r = a | b;
                4'd4: e.r = ~a;
                4'd5: e.r = 16'h0000 - a;
                4'd6: e.r = {a[14:0], 1'b0};
                4'd7: e.r = {a[15], a[15:1]};
                4'd8: e.r = b;
                default: e.il = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Handshakes are judged mid-cycle, where inputs and outputs are settled for the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 32'(result), 32'(e.r));
                    check("sb_bcond", 32'(bcond), 32'(e.bc));
                    check("sb_overflow", 32'(overflow), 32'(e.ov));
                    check("sb_illegal", 32'(illegal), 32'(e.il));
                end
                check("sb_count", 32'(retired_count), 32'(mcnt & 16'hFFFF));
                check("sb_count4", 32'(retired_count2), 32'(mcnt & 15));
                mcnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(funcCode, branchType, is_branch, A, B));
                nacc++;
            end
        end
    end

    task automatic set_op(input logic [3:0] f, input logic [1:0] bt, input logic br,
                          input logic [15:0] a, input logic [15:0] b);
        in_valid   = 1'b1;
        funcCode   = f;
        branchType = bt;
        is_branch  = br;
        A          = a;
        B          = b;
    endtask

    // Holds the operation on the inputs until an edge accepts it; returns just after that edge.
    task automatic send(input logic [3:0] f, input logic [1:0] bt, input logic br,
                        input logic [15:0] a, input logic [15:0] b);
        bit ok;
        set_op(f, bt, br, a, b);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !out_valid) return;
            step();
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        reset = 1'b1; out_ready = 1'b0;
        set_op(4'd0, 2'd0, 1'b0, 16'h0, 16'h0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({bcond, overflow, illegal}), 32'd0);
        check("rst_count", 32'(retired_count), 32'd0);

        // ADD overflow and two-edge latency
        set_op(4'b0000, 2'd0, 1'b0, 16'h7FFF, 16'h0001);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(result), 32'h8000);
        check("add_overflow", 32'(overflow), 32'd1);
        check("add_illegal", 32'(illegal), 32'd0);
        drain();

        // back-to-back SUB, SHR, TCP
        send(4'b0001, 2'd0, 1'b0, 16'd5, 16'd7);
        check("b2b_first_valid", 32'(out_valid), 32'd0);
        send(4'b0111, 2'd0, 1'b0, 16'h8004, 16'h0);
        check("b2b_sub", 32'(result), 32'hFFFE);
        send(4'b0101, 2'd0, 1'b0, 16'h0001, 16'h0);
        check("b2b_shr", 32'(result), 32'hC002);
        in_valid = 1'b0;
        step();
        check("b2b_tcp", 32'(result), 32'hFFFF);
        check("b2b_tcp_valid", 32'(out_valid), 32'd1);
        drain();
        check("b2b_count", 32'(retired_count), 32'd4);

        // branches; funcCode set to an illegal code to show it is ignored
        send(4'hF, 2'b01, 1'b1, 16'h1234, 16'h1234);
        send(4'hF, 2'b00, 1'b1, 16'h1234, 16'h1234);
        send(4'hF, 2'b10, 1'b1, 16'h0000, 16'h0000);
        send(4'hF, 2'b11, 1'b1, 16'h8000, 16'h0000);
        drain();
        check("blz_bcond", 32'(bcond), 32'd1);
        check("blz_result", 32'(result), 32'd0);

        // backpressure
        out_ready = 1'b0;
        base = nacc;
        set_op(4'b0000, 2'd0, 1'b0, 16'd1, 16'd2);
        step();
        set_op(4'b0010, 2'd0, 1'b0, 16'hF0F0, 16'hFF00);
        step();
        set_op(4'b0011, 2'd0, 1'b0, 16'h0F00, 16'h00F0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'd3);
        end
        check("bp_accepted", 32'(nacc - base), 32'd2);
        out_ready = 1'b1;
        send(4'b0011, 2'd0, 1'b0, 16'h0F00, 16'h00F0);
        drain();
        check("bp_all_accepted", 32'(nacc - base), 32'd3);
        check("bp_count", 32'(retired_count), 32'd11);

        // illegal code and pass-through
        send(4'b1011, 2'd0, 1'b0, 16'h1234, 16'h5678);
        send(4'b1000, 2'd0, 1'b0, 16'h1111, 16'hAB00);
        check("ill_result", 32'(result), 32'd0);
        check("ill_flag", 32'(illegal), 32'd1);
        in_valid = 1'b0;
        step();
        check("pass_result", 32'(result), 32'hAB00);
        check("pass_illegal", 32'(illegal), 32'd0);
        drain();

        // reset with both stages full
        out_ready = 1'b0;
        send(4'b0000, 2'd0, 1'b0, 16'd1, 16'd1);
        send(4'b0001, 2'd0, 1'b0, 16'd9, 16'd3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_count", 32'(retired_count), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        step();
        check("mid_rst_discarded", 32'(out_valid), 32'd0);

        // counter wrap on the narrow instance, random operations
        for (int i = 0; i < 16; i++)
            send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
        drain();
        check("wrap_count16", 32'(retired_count), 32'd16);
        check("wrap_count4", 32'(retired_count2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
